// File: rtl/quad_enc_decoder_if.sv
// rtl/quad_enc_decoder_if.sv - encoder line inputs and position/step outputs of quad_enc_decoder
//   a, b   : raw encoder channels (asynchronous to clk)
//   clr    : synchronous position clear
//   pos    : signed position count, CNT_W bits
//   step   : one-cycle pulse per accepted legal transition
//   dir    : direction of the last step (0 = up, 1 = down)
//   err    : one-cycle pulse on a diagonal (illegal) transition
interface quad_enc_decoder_if #(
    parameter int CNT_W = 16
);
    logic             a;
    logic             b;
    logic             clr;
    logic [CNT_W-1:0] pos;
    logic             step;
    logic             dir;
    logic             err;

    modport master (
        output a, b, clr,
        input  pos, step, dir, err
    );

    modport slave (
        input  a, b, clr,
        output pos, step, dir, err
    );
endinterface

// File: rtl/quad_enc_decoder.sv
// rtl/quad_enc_decoder.sv - quadrature encoder front end: sync, glitch filter, x4 decode, position counter
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : quad_enc_decoder_if slave (a, b, clr in; pos, step, dir, err out)
module quad_enc_decoder #(
    parameter int FILT_LEN = 4,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    quad_enc_decoder_if.slave  bus
);

    localparam int            FW       = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN);

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_t;

    // Channel index 1 = A, 0 = B, so a [1:0] vector reads as the {A,B} pair.
    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    logic [1:0]          filt_q,  filt_d;
    logic [1:0][FW-1:0]  dcnt_q,  dcnt_d;   // consecutive samples differing from filt
    logic [1:0][FW-1:0]  scnt_q,  scnt_d;   // consecutive samples equal to filt (saturating)
    logic [1:0]          warm_q,  warm_d;
    state_t              state_q, state_d;
    logic [1:0]          prev_q,  prev_d;
    logic [CNT_W-1:0]    pos_q,   pos_d;
    logic                step_q,  step_d;
    logic                dir_q,   dir_d;
    logic                err_q,   err_d;
    logic                stable;

    // Next {A,B} in the count-up direction: 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] cw_next(input logic [1:0] p);
        case (p)
            2'b00:   cw_next = 2'b10;
            2'b10:   cw_next = 2'b11;
            2'b11:   cw_next = 2'b01;
            default: cw_next = 2'b00;
        endcase
    endfunction

    always_comb begin
        sync1_d = {bus.a, bus.b};
        sync2_d = sync1_q;
        filt_d  = filt_q;
        dcnt_d  = '0;
        scnt_d  = '0;

        // The sync chain holds reset zeros for two edges; stability is only
        // counted once it carries real input samples, so INIT never locks
        // onto a reset artefact.
        warm_d = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;

        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (dcnt_q[i] == FILT_MAX - FW'(1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + FW'(1);
                end
            end else if (warm_q == 2'd2) begin
                scnt_d[i] = (scnt_q[i] == FILT_MAX) ? scnt_q[i] : scnt_q[i] + FW'(1);
            end
        end
    end

    assign stable = (scnt_q[0] == FILT_MAX) && (scnt_q[1] == FILT_MAX);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        pos_d   = pos_q;
        step_d  = 1'b0;
        err_d   = 1'b0;
        dir_d   = dir_q;

        case (state_q)
            ST_INIT: begin
                if (stable) begin
                    prev_d  = filt_q;
                    state_d = ST_TRACK;
                end
            end
            default: begin
                if (filt_q != prev_q) begin
                    prev_d = filt_q;
                    if (filt_q == cw_next(prev_q)) begin
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        pos_d  = pos_q + CNT_W'(1);
                    end else if (prev_q == cw_next(filt_q)) begin
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        pos_d  = pos_q - CNT_W'(1);
                    end else begin
                        err_d  = 1'b1;
                    end
                end
            end
        endcase

        // Clear overrides the count only; step/dir still report the transition.
        if (bus.clr) begin
            pos_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            dcnt_q  <= '0;
            scnt_q  <= '0;
            warm_q  <= '0;
            state_q <= ST_INIT;
            prev_q  <= '0;
            pos_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            dcnt_q  <= dcnt_d;
            scnt_q  <= scnt_d;
            warm_q  <= warm_d;
            state_q <= state_d;
            prev_q  <= prev_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign bus.pos  = pos_q;
    assign bus.step = step_q;
    assign bus.dir  = dir_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_quad_enc_decoder.sv
// tb/tb_quad_enc_decoder.sv - directed self-checking bench for quad_enc_decoder
module tb_quad_enc_decoder;

    logic clk = 1'b0;
    logic rst16;
    logic rst4;

    always #5 clk = ~clk;

    quad_enc_decoder_if #(.CNT_W(16)) if16 ();
    quad_enc_decoder_if #(.CNT_W(4))  if4 ();

    quad_enc_decoder #(.FILT_LEN(4), .CNT_W(16)) dut16 (
        .clk (clk),
        .rst (rst16),
        .bus (if16)
    );

    quad_enc_decoder #(.FILT_LEN(4), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (if4)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int step_n = 0, err_n = 0, cw_n = 0, ccw_n = 0, both_n = 0;
    int step_lat = 0, err_lat = 0, edge_cyc = 0;

    always @(negedge clk) begin
        if (if16.step) begin
            step_n++;
            if (if16.dir) ccw_n++;
            else          cw_n++;
            step_lat = cyc - edge_cyc;
        end
        if (if16.err) begin
            err_n++;
            err_lat = cyc - edge_cyc;
        end
        if (if16.step && if16.err) both_n++;
    end

    task automatic drive16(input logic na, input logic nb);
        @(negedge clk);
        if16.a   = na;
        if16.b   = nb;
        edge_cyc = cyc + 1;
        repeat (20) @(negedge clk);
    endtask

    task automatic drive4(input logic na, input logic nb);
        @(negedge clk);
        if4.a = na;
        if4.b = nb;
        repeat (20) @(negedge clk);
    endtask

    logic [1:0] cw_seq  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] ccw_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] up5_seq [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};

    initial begin
        int s0, e0, c0, k0;

        rst16 = 1'b0;
        rst4  = 1'b0;
        if16.a = 1'b0; if16.b = 1'b0; if16.clr = 1'b0;
        if4.a  = 1'b0; if4.b  = 1'b0; if4.clr  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pos",   32'(if16.pos),  32'h0);
        check("rst_step",  32'(if16.step), 32'h0);
        check("rst_dir",   32'(if16.dir),  32'h0);
        check("rst_err",   32'(if16.err),  32'h0);
        check("rst_pos4",  32'(if4.pos),   32'h0);
        rst16 = 1'b1;
        rst4  = 1'b1;
        repeat (20) @(negedge clk);

        // One CW cycle: +1 per edge, 6-cycle latency each
        for (int i = 0; i < 4; i++) begin
            s0 = step_n;
            drive16(cw_seq[i][1], cw_seq[i][0]);
            check("cw_step", step_n - s0, 1);
            check("cw_dir",  32'(if16.dir), 32'h0);
            check("cw_lat",  step_lat, 6);
        end
        check("cw_pos",  32'(if16.pos), 32'h4);
        check("cw_cnt",  cw_n, 4);
        check("cw_err",  err_n, 0);

        // Two CCW cycles: 4 -> 0 -> -4
        for (int i = 0; i < 4; i++) begin
            drive16(ccw_seq[i][1], ccw_seq[i][0]);
            check("ccw_dir", 32'(if16.dir), 32'h1);
        end
        check("ccw_pos0", 32'(if16.pos), 32'h0);
        for (int i = 0; i < 4; i++) drive16(ccw_seq[i][1], ccw_seq[i][0]);
        check("ccw_pos_neg", 32'(if16.pos), 32'hFFFC);
        check("ccw_cnt", ccw_n, 8);

        // 3-cycle glitch on A is discarded
        s0 = step_n; e0 = err_n;
        @(negedge clk); if16.a = 1'b1;
        repeat (3) @(negedge clk); if16.a = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch3_step", step_n - s0, 0);
        check("glitch3_err",  err_n - e0, 0);
        check("glitch3_pos",  32'(if16.pos), 32'hFFFC);

        // 4-cycle pulse is accepted: up then down
        c0 = cw_n; k0 = ccw_n; e0 = err_n;
        @(negedge clk); if16.a = 1'b1;
        repeat (4) @(negedge clk); if16.a = 1'b0;
        repeat (20) @(negedge clk);
        check("pulse4_cw",  cw_n - c0, 1);
        check("pulse4_ccw", ccw_n - k0, 1);
        check("pulse4_dir", 32'(if16.dir), 32'h1);
        check("pulse4_err", err_n - e0, 0);
        check("pulse4_pos", 32'(if16.pos), 32'hFFFC);

        // Diagonal 00 -> 11 gives a single err, no step
        s0 = step_n; e0 = err_n;
        drive16(1'b1, 1'b1);
        check("diag_err",  err_n - e0, 1);
        check("diag_lat",  err_lat, 6);
        check("diag_step", step_n - s0, 0);
        check("diag_pos",  32'(if16.pos), 32'hFFFC);
        drive16(1'b0, 1'b1);
        check("after_diag_pos", 32'(if16.pos), 32'hFFFD);
        check("after_diag_dir", 32'(if16.dir), 32'h0);

        // Clear, then count up to 5 from state 01
        @(negedge clk); if16.clr = 1'b1;
        @(negedge clk); if16.clr = 1'b0;
        check("clr_pos", 32'(if16.pos), 32'h0);
        for (int i = 0; i < 5; i++) drive16(up5_seq[i][1], up5_seq[i][0]);
        check("up5_pos", 32'(if16.pos), 32'h5);

        // Asynchronous reset mid-cycle, release with A=B=1 held
        @(posedge clk); #3;
        rst16 = 1'b0;
        #1;
        check("async_rst_pos", 32'(if16.pos), 32'h0);
        if16.a = 1'b1; if16.b = 1'b1;
        repeat (3) @(negedge clk);
        s0 = step_n; e0 = err_n;
        rst16 = 1'b1;
        repeat (30) @(negedge clk);
        check("reinit_step", step_n - s0, 0);
        check("reinit_err",  err_n - e0, 0);
        check("reinit_pos",  32'(if16.pos), 32'h0);
        drive16(1'b1, 1'b0);
        check("reinit_ccw_pos", 32'(if16.pos), 32'hFFFF);
        check("reinit_ccw_dir", 32'(if16.dir), 32'h1);
        check("never_both", both_n, 0);

        // 4-bit counter: wrap +7 -> -8, then clr coincident with a step
        for (int i = 0; i < 7; i++) drive4(cw_seq[i % 4][1], cw_seq[i % 4][0]);
        check("w4_pos7", 32'(if4.pos), 32'h7);
        drive4(cw_seq[3][1], cw_seq[3][0]);
        check("w4_wrap", 32'(if4.pos), 32'h8);
        @(negedge clk); if4.a = 1'b1; if4.b = 1'b0;
        repeat (6) @(negedge clk);
        if4.clr = 1'b1;
        @(negedge clk);
        check("w4_clr_step", 32'(if4.step), 32'h1);
        check("w4_clr_dir",  32'(if4.dir),  32'h0);
        check("w4_clr_pos",  32'(if4.pos),  32'h0);
        if4.clr = 1'b0;
        repeat (20) @(negedge clk);
        check("w4_clr_hold", 32'(if4.pos), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
